// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: operand/product widths, default SHIFT and MULT_LAT, signed operand and product types
package mult_share_arbiter_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int DEF_SHIFT = 6;
  localparam int DEF_MULT_LAT = 1;
  typedef logic signed [OP_W-1:0] op_t;
  typedef logic signed [PROD_W-1:0] prod_t;
endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: bus bundle; slave=arbiter (in: req, op_a, op_b, mult_result; out: gnt, mult_a, mult_b, res_valid, res_data)
interface mult_share_arbiter_if
  import mult_share_arbiter_pkg::*;
#(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req;
  logic [N_REQ*OP_W-1:0] op_a;
  logic [N_REQ*OP_W-1:0] op_b;
  logic [N_REQ-1:0] gnt;
  op_t mult_a;
  op_t mult_b;
  prod_t mult_result;
  logic [N_REQ-1:0] res_valid;
  prod_t res_data;
  modport slave (input req, op_a, op_b, mult_result, output gnt, mult_a, mult_b, res_valid, res_data);
  modport master (output req, op_a, op_b, mult_result, input gnt, mult_a, mult_b, res_valid, res_data);
endinterface

// File: rtl/mult_share_arbiter_tag_pipe.sv
// mult_tag_pipe: DEPTH-stage {valid, tag} delay line; ports clk, rst, i_valid/i_tag in, o_valid/o_tag out; valid clears on rst
module mult_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag
);
  logic r_valid [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  always_ff @(posedge clk) begin
    r_valid[0] <= rst ? 1'b0 : i_valid;
    r_tag[0] <= i_tag;
    for (int s = 1; s < DEPTH; s++) begin
      r_valid[s] <= rst ? 1'b0 : r_valid[s-1];
      r_tag[s] <= r_tag[s-1];
    end
  end
  assign o_valid = r_valid[DEPTH-1];
  assign o_tag = r_tag[DEPTH-1];
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external 8x8 multiplier; ports clk, rst, bus (slave: req/op_a/op_b/mult_result in, gnt/mult_a/mult_b/res_valid/res_data out)
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int SHIFT = DEF_SHIFT
) (
  input logic clk,
  input logic rst,
  mult_share_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_j;
  logic [IW-1:0] w_tag;
  logic w_any;
  logic w_grant;
  logic w_tvalid;
  op_t w_a [N_REQ];
  op_t w_b [N_REQ];
  op_t r_mult_a;
  op_t r_mult_b;
  logic [N_REQ-1:0] r_res_valid;
  prod_t r_res_data;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_a[i] = bus.op_a[i*OP_W +: OP_W];
    assign w_b[i] = bus.op_b[i*OP_W +: OP_W];
  end
  // scan offsets from the far end down so the requester nearest the pointer is the last writer and wins
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_ptr) + k) % N_REQ);
      if (bus.req[w_j]) begin
        w_any = 1'b1;
        w_idx = w_j;
      end
    end
  end
  assign w_grant = w_any & ~rst;
  assign bus.gnt = w_grant ? (N_REQ'(1) << w_idx) : '0;
  assign bus.mult_a = r_mult_a;
  assign bus.mult_b = r_mult_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data = r_res_data;
  // one stage for the operand register plus MULT_LAT stages inside the external multiplier
  mult_tag_pipe #(.DEPTH(1 + MULT_LAT), .TAG_W(IW)) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .i_valid(w_grant),
    .i_tag(w_idx),
    .o_valid(w_tvalid),
    .o_tag(w_tag)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_res_valid <= '0;
      r_res_data <= '0;
    end else begin
      if (w_grant) begin
        r_ptr <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
        r_mult_a <= w_a[w_idx];
        r_mult_b <= w_b[w_idx];
      end
      r_res_valid <= w_tvalid ? (N_REQ'(1) << w_tag) : '0;
      if (w_tvalid) r_res_data <= bus.mult_result >>> SHIFT;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench with a round-robin/scoreboard model checked every cycle plus literal expectations
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;
  localparam int N = 4;
  localparam int LAT = 3;
  typedef struct {
    int    due;
    int    idx;
    prod_t val;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;
  op_t m_a = '0;
  op_t m_b = '0;
  prod_t m_data = '0;
  ent_t q[$];
  mult_share_arbiter_if #(.N_REQ(N)) bus ();
  mult_share_arbiter #(.N_REQ(N), .MULT_LAT(1), .SHIFT(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic prod_t mul(op_t a, op_t b);
    int p;
    p = int'(a) * int'(b);
    return prod_t'(p);
  endfunction
  function automatic int scaled(op_t a, op_t b);
    return (int'(a) * int'(b)) >>> 6;
  endfunction
  function automatic int rr(int p, logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic op_t sl(logic [N*8-1:0] v, int i);
    return op_t'(v[i*8 +: 8]);
  endfunction
  // external shared multiplier, one registered stage
  always_ff @(posedge clk) bus.mult_result <= mul(bus.mult_a, bus.mult_b);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, want);
    end
  endtask
  always @(negedge clk) begin
    int g;
    logic [N-1:0] ev;
    g = rst ? -1 : rr(m_ptr, bus.req);
    chk("gnt", bus.gnt, g < 0 ? 0 : 1 << g);
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = N'(1) << q[0].idx;
      m_data = q[0].val;
      void'(q.pop_front());
    end
    chk("res_valid", bus.res_valid, ev);
    chk("res_data", bus.res_data, m_data);
    chk("mult_a", bus.mult_a, m_a);
    chk("mult_b", bus.mult_b, m_b);
    if (rst) begin
      m_ptr = 0;
      m_a = '0;
      m_b = '0;
      m_data = '0;
      q.delete();
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_a = sl(bus.op_a, g);
      m_b = sl(bus.op_b, g);
      q.push_back('{due: cyc + LAT, idx: g, val: prod_t'(scaled(m_a, m_b))});
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(int i, int a, int b);
    bus.op_a[i*8 +: 8] = 8'(a);
    bus.op_b[i*8 +: 8] = 8'(b);
  endtask
  task automatic single(int i, int a, int b, int res);
    setop(i, a, b);
    bus.req = N'(1) << i;
    @(negedge clk);
    chk("single_gnt", bus.gnt, 1 << i);
    tick();
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("single_valid", bus.res_valid, 1 << i);
    chk("single_data", bus.res_data, prod_t'(res));
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int waited;
    bus.req = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    single(0, 60, 64, 60);
    single(0, 60, -128, -120);
    single(0, -1, 1, -1);
    do_reset();
    for (int i = 0; i < N; i++) setop(i, 10 * i + 3, 20 - 7 * i);
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_seq", bus.gnt, 1 << (k % N));
      tick();
      setop(k % N, 17 * k - 50, 90 - 23 * k);
    end
    bus.req = '0;
    repeat (4) tick();
    do_reset();
    single(1, 100, 100, 156);
    bus.req = 4'b0011;
    @(negedge clk);
    chk("wrap_gnt", bus.gnt, 4'b0001);
    tick();
    @(negedge clk);
    chk("wrap_ptr", bus.gnt, 4'b0010);
    tick();
    bus.req = '0;
    repeat (4) tick();
    bus.req = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    bus.req = 4'b0110;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 4'b0010);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    tick();
    bus.req = '0;
    @(negedge clk);
    chk("rst_valid_later", bus.res_valid, 0);
    repeat (4) tick();
    do_reset();
    bus.req = 4'b1001;
    waited = 99;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.gnt[3]) begin
        waited = k;
        break;
      end
      tick();
    end
    chk("fair_cycles", waited, 1);
    tick();
    bus.req = '0;
    repeat (6) tick();
    chk("drain_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 N_REQ, 4, number of requesters sharing one 8x8 signed multiplier (2..8).
REQ-002 MULT_LAT, 1, clock cycles from multiplier operand input to registered result.
REQ-003 SHIFT, 6, arithmetic right shift applied to the product (60/64-style coefficient scaling).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester multiply request, held high until granted.
REQ-007 op_a  input  N_REQ*8  signed coefficient per requester, slice i = [8i+7:8i].
REQ-008 op_b  input  N_REQ*8  signed sample per requester, same slicing.
REQ-009 gnt  output  N_REQ  one-hot grant, combinational from req and priority pointer.
REQ-010 mult_a  output  8  registered signed operand A to the shared multiplier.
REQ-011 mult_b  output  8  registered signed operand B to the shared multiplier.
REQ-012 mult_result  input  16  signed product from the shared multiplier.
REQ-013 res_valid  output  N_REQ  one-hot, one-cycle strobe marking the owner of res_data.
REQ-014 res_data  output  16  registered signed result, mult_result >>> SHIFT.

Function
REQ-015 At most one gnt bit SHALL be high per cycle; gnt SHALL be zero when req is zero.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer ptr, wraps N_REQ-1 to 0; first requesting index wins.
REQ-017 On a grant to index g, ptr SHALL become (g+1) mod N_REQ at the clock edge; with no grant ptr SHALL hold.
REQ-018 On the granting edge op_a/op_b slice g SHALL be captured into mult_a/mult_b; with no grant mult_a/mult_b SHALL hold.
REQ-019 A tag pipeline SHALL carry {valid, g} for 1+MULT_LAT stages alongside the operands.
REQ-020 res_valid bit g and res_data SHALL be registered exactly 2+MULT_LAT cycles after the granting edge's cycle (latency 3 at default).
REQ-021 res_data SHALL be sign-extended arithmetic shift of mult_result by SHIFT; no saturation; width stays 16.
REQ-022 One new grant per cycle SHALL be sustained; back-to-back results SHALL emerge in grant order with no gaps or reordering.
REQ-023 A requester re-asserting req in the cycle after its grant SHALL wait for all other pending requesters (fairness bound N_REQ-1 cycles).
REQ-024 res_data SHALL hold its last value when res_valid is zero.

Reset
REQ-025 On rst: ptr=0, gnt combinationally zero, mult_a=0, mult_b=0, res_valid=0, res_data=0, all tag pipeline valid bits cleared.
REQ-026 Reset mid-operation SHALL discard in-flight products: no res_valid for any grant issued before or during rst.
REQ-027 req SHALL be ignored while rst is high; arbitration resumes from index 0 on the first cycle after rst falls.

Structure
REQ-028 Shared package SHALL hold operand width (8), product width (16), default SHIFT and default MULT_LAT constants.
REQ-029 The tag/valid delay line SHALL be a separate sub-module, mult_tag_pipe, parameterised by depth and tag width.
REQ-030 The multiplier itself SHALL stay outside this block; the block only drives operands and consumes the product.

Verification
REQ-031 Single request: req=0001, op_a=60, op_b=64 -> gnt=0001 same cycle; res_valid=0001, res_data=60 three cycles later.
REQ-032 All four requesting continuously from reset -> grants 0001,0010,0100,1000,0001... one per cycle; results in same order, no gaps.
REQ-033 Negative operands: op_a=60, op_b=-128 -> res_data=-120 (-7680>>>6); op_a=-1, op_b=1 -> res_data=-1.
REQ-034 ptr=2, req=0011 -> gnt=0001 (wrap-around), next ptr=1.
REQ-035 rst pulsed one cycle after two grants issued -> no res_valid for either; outputs zero; next grant to lowest requesting index.
REQ-036 Requester 0 re-requests every cycle with requester 3 pending -> requester 3 granted within 3 cycles.
